// File: rtl/adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and default sizing.
package adder_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_CNT_W = 5;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/serial_adder16_if.sv
// Request/result bundle between a requester (master) and the serial adder (slave).
interface serial_adder16_if import adder_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH
) ();

    logic             i_start;
    logic [WIDTH-1:0] i_a;
    logic [WIDTH-1:0] i_b;
    logic             i_cin;
    logic             o_busy;
    logic             o_done;
    logic [WIDTH-1:0] o_sum;
    logic             o_cout;
    logic             o_overflow;

    modport master (
        output i_start, i_a, i_b, i_cin,
        input  o_busy, o_done, o_sum, o_cout, o_overflow
    );

    modport slave (
        input  i_start, i_a, i_b, i_cin,
        output o_busy, o_done, o_sum, o_cout, o_overflow
    );

endinterface

// File: rtl/full_adder.sv
// One-bit full adder cell, driven one bit pair per clock by serial_adder16.
module full_adder (
    input  logic X,
    input  logic Y,
    input  logic Cin,
    output logic Sum,
    output logic Cout
);

    assign Sum  = X ^ Y ^ Cin;
    assign Cout = (X & Y) | (Cin & (X ^ Y));

endmodule

// File: rtl/serial_adder16.sv
// Bit-serial adder: latches operands on Start, adds LSB first through one full_adder,
// then presents the registered result alongside a one-cycle Done pulse.
module serial_adder16 import adder_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    serial_adder16_if.slave  bus
);

    state_t           r_state;
    state_t           w_next;
    logic             w_load;
    logic             w_last;

    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_psum;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;

    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;

    logic             w_fa_sum;
    logic             w_fa_cout;

    full_adder u_fa (
        .X    (r_a_sh[0]),
        .Y    (r_b_sh[0]),
        .Cin  (r_carry),
        .Sum  (w_fa_sum),
        .Cout (w_fa_cout)
    );

    assign w_last = (r_state == S_SHIFT) && (r_cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Start is only honoured from IDLE or DONE; requests during SHIFT are dropped.
    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.i_start) begin
                    w_next = S_SHIFT;
                    w_load = 1'b1;
                end
            end
            S_SHIFT: begin
                if (w_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.i_start) begin
                    w_next = S_SHIFT;
                    w_load = 1'b1;
                end else begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_psum  <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
        end else if (w_load) begin
            r_a_sh  <= bus.i_a;
            r_b_sh  <= bus.i_b;
            r_psum  <= '0;
            r_carry <= bus.i_cin;
            r_cnt   <= '0;
        end else if (r_state == S_SHIFT) begin
            r_a_sh  <= {1'b0, r_a_sh[WIDTH-1:1]};
            r_b_sh  <= {1'b0, r_b_sh[WIDTH-1:1]};
            r_psum  <= {w_fa_sum, r_psum[WIDTH-1:1]};
            r_carry <= w_fa_cout;
            r_cnt   <= r_cnt + CNT_W'(1);
        end
    end

    // On the MSB step r_carry is the carry into the MSB, so overflow needs no extra state.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sum  <= '0;
            r_cout <= 1'b0;
            r_ovf  <= 1'b0;
        end else if (w_last) begin
            r_sum  <= {w_fa_sum, r_psum[WIDTH-1:1]};
            r_cout <= w_fa_cout;
            r_ovf  <= r_carry ^ w_fa_cout;
        end
    end

    assign bus.o_busy     = (r_state == S_SHIFT);
    assign bus.o_done     = (r_state == S_DONE);
    assign bus.o_sum      = r_sum;
    assign bus.o_cout     = r_cout;
    assign bus.o_overflow = r_ovf;

endmodule

// File: tb/tb_serial_adder16.sv
// Self-checking bench for serial_adder16: directed cases with literal results plus a
// randomized run, all compared every cycle against an arithmetic reference model.
module tb_serial_adder16;

    localparam int W = 16;

    logic clk;
    logic rst_n;
    int   nChecks = 0;
    int   nPass   = 0;
    bit   checkEn = 0;

    serial_adder16_if #(.WIDTH(W)) bus ();

    serial_adder16 #(.WIDTH(W), .CNT_W(5)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: remembers A+B+Cin at acceptance and publishes it W edges later.
    int           mLeft     = 0;
    bit           mDone     = 0;
    logic [W-1:0] mSum      = '0;
    logic         mCout     = 1'b0;
    logic         mOvf      = 1'b0;
    logic [W:0]   pendFull  = '0;
    logic         pendOvf   = 1'b0;
    int           doneCount = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mLeft = 0;
            mDone = 0;
            mSum  = '0;
            mCout = 1'b0;
            mOvf  = 1'b0;
        end else if (mLeft > 0) begin
            mLeft = mLeft - 1;
            mDone = (mLeft == 0);
            if (mLeft == 0) begin
                {mCout, mSum} = pendFull;
                mOvf = pendOvf;
                doneCount++;
            end
        end else begin
            mDone = 0;
            if (bus.i_start) begin
                pendFull = {1'b0, bus.i_a} + {1'b0, bus.i_b} + {{W{1'b0}}, bus.i_cin};
                pendOvf  = (bus.i_a[W-1] == bus.i_b[W-1]) && (pendFull[W-1] != bus.i_a[W-1]);
                mLeft    = W;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act === exp) begin
            nPass++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("cycle {busy,done,cout,ovf,sum}",
                        {bus.o_busy, bus.o_done, bus.o_cout, bus.o_overflow, bus.o_sum},
                        {mLeft > 0, mDone, mCout, mOvf, mSum});
        end
    end

    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        @(negedge clk);
        bus.i_start = 1'b1;
        bus.i_a     = a;
        bus.i_b     = b;
        bus.i_cin   = cin;
        @(negedge clk);
        bus.i_start = 1'b0;
    endtask

    // Counts edges from the current sample until Done is seen, bounded.
    task automatic waitDone(output int n, output int busyCnt);
        n = 0;
        busyCnt = 0;
        while (!bus.o_done && n < 40) begin
            if (bus.o_busy) busyCnt++;
            @(negedge clk);
            n++;
        end
        checkOutput("done seen", bus.o_done, 1);
    endtask

    task automatic runAdd(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input logic [W-1:0] eSum, input logic eCout,
                          input logic eOvf);
        int n, busyCnt;
        applyStimulus(a, b, cin);
        waitDone(n, busyCnt);
        checkOutput({name, " latency"}, n, 16);
        checkOutput({name, " busy cycles"}, busyCnt, 16);
        checkOutput({name, " sum"}, bus.o_sum, eSum);
        checkOutput({name, " cout"}, bus.o_cout, eCout);
        checkOutput({name, " overflow"}, bus.o_overflow, eOvf);
    endtask

    initial begin
        int n, busyCnt, dones, cycles, base;
        rst_n       = 1'b0;
        bus.i_start = 1'b0;
        bus.i_a     = '0;
        bus.i_b     = '0;
        bus.i_cin   = 1'b0;
        #1 checkEn  = 1;

        repeat (3) @(negedge clk);
        checkOutput("reset state",
                    {bus.o_busy, bus.o_done, bus.o_cout, bus.o_overflow, bus.o_sum}, 0);
        rst_n = 1'b1;

        runAdd("1234+4321", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
        runAdd("FFFF+0001", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        runAdd("FFFF+FFFF+1", 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0);
        runAdd("7FFF+0001", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        runAdd("8000+8000", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);

        // Start pulsed mid-operation must be ignored.
        applyStimulus(16'h1234, 16'h4321, 1'b0);
        n = 0;
        while (!bus.o_done && n < 40) begin
            if (n == 5) begin
                bus.i_start = 1'b1;
                bus.i_a     = '0;
                bus.i_b     = '0;
            end
            if (n == 6) bus.i_start = 1'b0;
            @(negedge clk);
            n++;
        end
        checkOutput("ignore-start latency", n, 16);
        checkOutput("ignore-start sum", bus.o_sum, 16'h5555);
        dones = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.o_done) dones++;
        end
        checkOutput("ignore-start extra dones", dones, 0);

        // Asynchronous reset in the middle of an operation.
        runAdd("0F0F+0101", 16'h0F0F, 16'h0101, 1'b0, 16'h1010, 1'b0, 1'b0);
        applyStimulus(16'h1234, 16'h4321, 1'b0);
        repeat (8) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 checkOutput("async reset outputs",
                       {bus.o_busy, bus.o_done, bus.o_cout, bus.o_overflow, bus.o_sum}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.o_done) dones++;
        end
        checkOutput("no done after abort", dones, 0);
        runAdd("0003+0004", 16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0);

        // Back-to-back: Start held in the DONE cycle.
        applyStimulus(16'h1111, 16'h2222, 1'b0);
        waitDone(n, busyCnt);
        checkOutput("b2b first sum", bus.o_sum, 16'h3333);
        bus.i_start = 1'b1;
        bus.i_a     = 16'h00FF;
        bus.i_b     = 16'h0F01;
        bus.i_cin   = 1'b0;
        @(negedge clk);
        bus.i_start = 1'b0;
        waitDone(n, busyCnt);
        checkOutput("b2b done spacing", n + 1, 17);
        checkOutput("b2b second sum", bus.o_sum, 16'h1000);
        checkOutput("b2b second cout", bus.o_cout, 1'b0);

        // Random regression: Start and operands toggle freely, model checks every cycle.
        base   = doneCount;
        cycles = 0;
        while (doneCount - base < 1000 && cycles < 40000) begin
            @(negedge clk);
            bus.i_start = ($urandom_range(0, 1) == 0);
            bus.i_a     = W'($urandom);
            bus.i_b     = W'($urandom);
            bus.i_cin   = 1'($urandom);
            cycles++;
        end
        checkOutput("random adds completed", doneCount - base >= 1000, 1);
        bus.i_start = 1'b0;
        repeat (20) @(negedge clk);

        checkEn = 0;
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule

// File: doc/serial_adder16.md
Name: serial_adder16

Overview:
- Bit-serial multi-bit adder built around the existing full_adder cell.
- Latches two WIDTH-bit operands and a carry-in on a start handshake.
- Feeds the full_adder one bit pair per clock, LSB first, and recirculates its Cout through a carry register.
- Collects the Sum bits, then presents the registered result with a one-cycle Done pulse. It is the sequencing stage directly upstream and downstream of full_adder: it both feeds the cell and consumes its outputs.

Parameters:
- WIDTH, 16, operand and result width in bits (legal range 2..32).
- CNT_W, 5, bit-counter width; must satisfy 2**CNT_W > WIDTH.

Ports:
- Clk  input  1  single clock; all state updates on rising edge.
- Rst_n  input  1  reset; asynchronous, active-low.
- Start  input  1  request; sampled on the rising edge; accepted only in IDLE or DONE.
- A  input  WIDTH  operand A; sampled with accepted Start.
- B  input  WIDTH  operand B; sampled with accepted Start.
- Cin  input  1  carry-in; sampled with accepted Start.
- Busy  output  1  high while bits are being added (SHIFT state).
- Done  output  1  one-cycle pulse: result valid.
- Sum  output  WIDTH  registered result; held until the next completion.
- Cout  output  1  registered final carry-out.
- Overflow  output  1  registered signed overflow: carry into MSB XOR final carry-out.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (Rst_n=0, any time, including mid-operation):
  - state=IDLE; Busy=0, Done=0, Sum=0, Cout=0, Overflow=0.
  - Operand shift registers, carry register, partial-sum register and counter all cleared.
  - An aborted operation produces no Done and no result update.
- States:
  - IDLE: waiting for a request.
  - SHIFT: adding one bit pair per cycle.
  - DONE: one cycle, result valid.
  - Encoding: 2-bit.
- IDLE / DONE with Start=1 at edge E0:
  - Load A and B into right-shift registers.
  - carry <- Cin; count <- 0; state <- SHIFT.
- IDLE with Start=0: remain in IDLE.
- SHIFT, each edge:
  - full_adder inputs: X = A_sh[0], Y = B_sh[0], Cin = carry.
  - Shift A_sh and B_sh right by one.
  - carry <- full_adder Cout.
  - Partial sum register shifts right with the full_adder Sum entering at the MSB.
  - count <- count+1.
- Bit WIDTH-1 step (count==WIDTH-1, edge E_WIDTH):
  - Sum <- final partial value; Cout <- full_adder Cout.
  - Overflow <- carry (carry into MSB) XOR full_adder Cout.
  - state <- DONE.
- DONE: Done=1 for exactly one cycle. Next state is SHIFT if Start=1, else IDLE.
- Latency: Start accepted at E0; Busy high from after E0 through E_WIDTH; Done high in the cycle after E_WIDTH. Throughput is one add per WIDTH+1 cycles, back-to-back.
- Start during SHIFT is ignored: no reload, no error flag, the operation in flight completes unchanged.
- A, B and Cin changes after E0 have no effect on the operation in flight.
- Sum, Cout and Overflow keep the previous result during SHIFT and change only at E_WIDTH.
- Arithmetic: unsigned modulo 2**WIDTH. {Cout,Sum} == A+B+Cin must hold at every Done.
- Done and Busy are never high in the same cycle.

Decomposition:
- Shared package adder_pkg holds:
  - state encodings: S_IDLE=2'd0, S_SHIFT=2'd1, S_DONE=2'd2;
  - the default WIDTH;
  - CNT_W.
- Unused encoding 2'd3 recovers to IDLE.
- Sub-module: exactly one instance of the existing full_adder (ports X, Y, Cin, Sum, Cout).
- Control FSM, shift registers and carry register live in serial_adder16.

Test Plan:
- A=16'h1234, B=16'h4321, Cin=0, Start one cycle -> Done exactly 16 cycles after E0 (in the cycle after E16); Sum=16'h5555, Cout=0, Overflow=0; Busy high for 16 cycles.
- A=16'hFFFF, B=16'h0001, Cin=0 -> Sum=16'h0000, Cout=1, Overflow=0. Then A=16'hFFFF, B=16'hFFFF, Cin=1 -> Sum=16'hFFFF, Cout=1, Overflow=0.
- A=16'h7FFF, B=16'h0001, Cin=0 -> Sum=16'h8000, Cout=0, Overflow=1. Then A=16'h8000, B=16'h8000 -> Sum=16'h0000, Cout=1, Overflow=1.
- Start pulsed at cycle 5 of SHIFT with A=B=16'h0000 -> ignored; the original result (16'h5555 case) is delivered at the normal time, with exactly one Done.
- Rst_n driven low at cycle 8 of SHIFT -> all outputs 0 immediately (asynchronously); no Done afterwards. A new Start after reset release computes 16'h0003+16'h0004 -> 16'h0007.
- Start held high in the DONE cycle with the next operands -> second add starts with no IDLE gap; second Done 17 cycles after the first. Random regression: 1000 operand sets, each checks {Cout,Sum}==A+B+Cin.
